// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: state type, sizing helpers and underrun fill selection (I2S_TX_UNDERRUN_HOLD_EN picks hold vs mute).
package i2s_tx_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int frame_len(input int fxp_size);
    return 2 * fxp_size;
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam bit UNDERRUN_HOLD = 1'b1;
`else
  localparam bit UNDERRUN_HOLD = 1'b0;
`endif
endpackage

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: valid-strobed sample stream from the effects pipeline into the serializer.
interface i2s_tx_serializer_if #(parameter int W = 16);
  logic         i_valid;
  logic [W-1:0] i_sample;
  logic         o_ready;
  modport master (output i_valid, i_sample, input o_ready);
  modport slave  (input i_valid, i_sample, output o_ready);
endinterface

// File: rtl/sync_sample_fifo.sv
// sync_sample_fifo: power-of-two sample FIFO with wrap-bit pointers and a show-ahead head.
module sync_sample_fifo import i2s_tx_pkg::*; #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int PW = ptr_w(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop) r_rd <= r_rd + PW'(1);
    end
  end
  always_ff @(posedge clk) if (i_push) r_mem[r_wr[PW-2:0]] <= i_data;
  assign o_full  = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[PW-2:0] == r_rd[PW-2:0]);
  assign o_empty = r_wr == r_rd;
  assign o_head  = r_mem[r_rd[PW-2:0]];
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: FIFO-buffered mono sample to I2S serializer (both slots), bclk/lrclk generation, sticky overflow/underrun.
module i2s_tx_serializer import i2s_tx_pkg::*; #(
  parameter int fxp_size   = 16,
  parameter int bclk_div   = 16,
  parameter int fifo_depth = 4
) (
  input  logic                clk,
  input  logic                rst,
  i2s_tx_serializer_if.slave  s_in,
  output logic                o_bclk,
  output logic                o_lrclk,
  output logic                o_sdata,
  output logic                o_overflow,
  output logic                o_underrun
);
  localparam int N  = frame_len(fxp_size);
  localparam int DW = $clog2(bclk_div);
  localparam int BW = $clog2(N);
  logic [DW-1:0]       r_div_cnt;
  logic [BW-1:0]       r_bit_cnt, w_bit_nxt;
  logic [N-1:0]        r_sr;
  logic [fxp_size-1:0] r_last, w_head, w_word;
  state_t              r_state, w_state_nxt;
  logic                w_tc, w_fall, w_start, w_pop, w_push, w_full, w_empty, w_underrun;
  assign w_tc      = r_div_cnt == DW'(bclk_div - 1);
  assign w_fall    = w_tc && o_bclk;
  assign w_start   = w_fall && (r_bit_cnt == BW'(N - 1));
  assign w_pop     = w_start && !w_empty;
  assign w_push    = s_in.i_valid && (!w_full || w_pop);
  assign w_bit_nxt = w_start ? '0 : r_bit_cnt + BW'(1);
  assign s_in.o_ready = !w_full;
  sync_sample_fifo #(.W(fxp_size), .DEPTH(fifo_depth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (s_in.i_sample),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    w_underrun  = 1'b0;
    w_word      = '0;
    if (w_pop) begin
      w_state_nxt = RUN;
      w_word      = w_head;
    end else if (w_start && r_state == RUN) begin
      w_underrun = 1'b1;
      w_word     = UNDERRUN_HOLD ? r_last : '0;
    end
  end
  // sdata emits the old MSB while the new word loads, giving the one-bclk I2S delay
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= BW'(N - 1);
      r_sr       <= '0;
      r_last     <= '0;
      o_bclk     <= 1'b0;
      o_lrclk    <= 1'b1;
      o_sdata    <= 1'b0;
      o_overflow <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      r_div_cnt <= w_tc ? '0 : r_div_cnt + DW'(1);
      if (w_tc) o_bclk <= !o_bclk;
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        o_lrclk   <= w_bit_nxt >= BW'(fxp_size);
        o_sdata   <= r_sr[N-1];
        r_sr      <= w_start ? {w_word, w_word} : r_sr << 1;
      end
      if (w_pop) r_last <= w_head;
      if (w_underrun) o_underrun <= 1'b1;
      if (s_in.i_valid && w_full && !w_pop) o_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: frame-synchronous directed stimulus with an I2S-receiver monitor checking frames against a queue.
module tb_i2s_tx_serializer;
  localparam int W = 16;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic o_bclk, o_lrclk, o_sdata, o_overflow, o_underrun;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  i2s_tx_serializer_if #(.W(W)) s_if();
  i2s_tx_serializer #(.fxp_size(W), .bclk_div(16), .fifo_depth(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_in       (s_if),
    .o_bclk     (o_bclk),
    .o_lrclk    (o_lrclk),
    .o_sdata    (o_sdata),
    .o_overflow (o_overflow),
    .o_underrun (o_underrun)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    s_if.i_valid  = 1'b1;
    s_if.i_sample = d;
    @(posedge clk); #1;
    s_if.i_valid  = 1'b0;
  endtask

  task automatic wait_fs(output int cyc);
    logic p;
    bit seen;
    p = o_lrclk; seen = 1'b0; cyc = 0;
    while (!seen && cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
      seen = p && !o_lrclk;
      p = o_lrclk;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL frame_start_timeout: got no lrclk fall want one within 1100 clk");
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_bclk"}, o_bclk, 0);
    chk({nm, "_lrclk"}, o_lrclk, 1);
    chk({nm, "_sdata"}, o_sdata, 0);
    chk({nm, "_overflow"}, o_overflow, 0);
    chk({nm, "_underrun"}, o_underrun, 0);
    chk({nm, "_ready"}, s_if.o_ready, 1);
  endtask

  // receiver: a word is the 16 bits sampled on rising bclk up to and including an lrclk change
  logic [W-1:0] sh = '0, left = '0, e;
  int nbits = 0;
  bit primed = 1'b0, have_l = 1'b0;
  logic prev_lr = 1'b1;
  initial forever begin
    @(posedge o_bclk or negedge rst);
    if (!rst) begin
      nbits = 0; primed = 1'b0; have_l = 1'b0; prev_lr = 1'b1;
    end else begin
      #1;
      sh = {sh[W-2:0], o_sdata};
      nbits++;
      if (o_lrclk != prev_lr) begin
        if (primed) chk("slot_length", nbits, W);
        if (nbits == W) begin
          if (o_lrclk) begin
            left = sh; have_l = 1'b1;
          end else if (have_l) begin
            have_l = 1'b0;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_frame: got %0h/%0h want no frame", left, sh);
            end else begin
              e = exp_q.pop_front();
              chk("frame_left", left, e);
              chk("frame_right", sh, e);
            end
          end
        end
        primed = 1'b1;
        nbits = 0;
      end
      prev_lr = o_lrclk;
    end
  end

  initial begin
    int c, e_cnt, t0, cyc;
    logic p;
    rst = 1'b0;
    s_if.i_valid = 1'b0;
    s_if.i_sample = '0;
    repeat (3) @(posedge clk); #1;
    chk_reset_vals("reset");
    exp_q.push_back('0);
    @(negedge clk); rst = 1'b1;
    wait_fs(c); exp_q.push_back('0);
    p = o_bclk; e_cnt = 0; t0 = 0; cyc = -1;
    for (int i = 0; i < 200 && e_cnt < 2; i++) begin
      @(posedge clk); #1;
      if (!p && o_bclk) begin
        if (e_cnt == 1) cyc = i - t0;
        t0 = i; e_cnt++;
      end
      p = o_bclk;
    end
    chk("bclk_period", cyc, 32);
    wait_fs(c); exp_q.push_back('0);
    wait_fs(c);
    chk("lrclk_period", c, 1024);
    chk("idle_no_underrun", o_underrun, 0);
    push(16'hA5C3); exp_q.push_back(16'hA5C3);
    wait_fs(c); push(16'h7FFF); exp_q.push_back(16'h7FFF);
    wait_fs(c); push(16'h8000); exp_q.push_back(16'h8000);
    wait_fs(c); push(16'h1234); exp_q.push_back(16'h1234);
    wait_fs(c);
    chk("run_before_underrun", o_underrun, 0);
    exp_q.push_back(HOLD ? 16'h1234 : 16'h0000);
    wait_fs(c);
    chk("underrun_set", o_underrun, 1);
    chk("overflow_clear", o_overflow, 0);
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    chk("ready_full", s_if.o_ready, 0);
    push(16'h5555);
    chk("overflow_set", o_overflow, 1);
    exp_q.push_back(16'h1111);
    wait_fs(c); chk("ready_after_pop", s_if.o_ready, 1); exp_q.push_back(16'h2222);
    wait_fs(c); exp_q.push_back(16'h3333);
    wait_fs(c); exp_q.push_back(16'h4444);
    wait_fs(c); exp_q.push_back(HOLD ? 16'h4444 : 16'h0000);
    wait_fs(c); exp_q.push_back(HOLD ? 16'h4444 : 16'h0000);
    repeat (500) @(posedge clk); #1;
    push(16'h9999);
    #2 rst = 1'b0;
    exp_q.delete();
    #1 chk_reset_vals("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    exp_q.push_back('0);
    wait_fs(c);
    chk("post_reset_overflow", o_overflow, 0);
    chk("post_reset_underrun", o_underrun, 0);
    exp_q.push_back('0);
    wait_fs(c);
    chk("post_reset_idle", o_underrun, 0);
    push(16'hBEEF); exp_q.push_back(16'hBEEF);
    wait_fs(c);
    for (int i = 0; i < 1100 && exp_q.size() != 0; i++) @(posedge clk);
    chk("frames_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
